// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// Optional feature macro: WB_WAW_KILL_EN (adds a kill bit to buffered entries).
package wb_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned WAIT_W       = 4;
    localparam int unsigned CNT_W        = 2;
    localparam int unsigned FIFO_DEPTH   = 2;

    // One buffered muldiv result.
    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
`ifdef WB_WAW_KILL_EN
        logic                    kill;
`endif
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO of muldiv results; entry 0 is always the head.
// With WB_WAW_KILL_EN, buffered entries whose rd matches kill_rd_i are marked killed.
module wb_fifo2
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  wb_entry_t             entry_i,
    input  logic                  pop_i,
`ifdef WB_WAW_KILL_EN
    input  logic                  kill_en_i,
    input  logic [REG_ADDR_W-1:0] kill_rd_i,
`endif
    output wb_entry_t             head_o,
    output logic [CNT_W-1:0]      count_o
);

    wb_entry_t         ent0_q, ent0_d;
    wb_entry_t         ent1_q, ent1_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Next-state: mark kills on resident entries, then pop (shift), then push.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
`ifdef WB_WAW_KILL_EN
        if (kill_en_i) begin
            if ((count_q != CNT_W'(0)) && (ent0_q.rd == kill_rd_i)) begin
                ent0_d.kill = 1'b1;
            end
            if ((count_q == CNT_W'(FIFO_DEPTH)) && (ent1_q.rd == kill_rd_i)) begin
                ent1_d.kill = 1'b1;
            end
        end
`endif
        if (pop_i && (count_q != CNT_W'(0))) begin
            ent0_d  = ent1_d;
            count_d = count_q - CNT_W'(1);
        end
        if (push_i && (count_d != CNT_W'(FIFO_DEPTH))) begin
            if (count_d == CNT_W'(0)) begin
                ent0_d = entry_i;
            end else begin
                ent1_d = entry_i;
            end
            count_d = count_d + CNT_W'(1);
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between MEM/WB writeback and
// buffered multiply/divide results, with an anti-starvation stall of the pipeline.
// Optional feature macro: WB_WAW_KILL_EN (pipeline writes kill older buffered results to the same rd).
// XLEN must not exceed wb_pkg::XLEN_DEFAULT (buffer data width).
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_regwrite,
    input  logic                  wb_memtoreg,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_readdata,
    input  logic [XLEN-1:0]       wb_alu_result,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_data,
    output logic                  pipe_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [CNT_W-1:0]      buf_count
);

    wb_entry_t              head;
    wb_entry_t              push_entry;
    logic [CNT_W-1:0]       count;

    logic                   pipe_req_c;
    logic [XLEN-1:0]        pipe_data_c;
    logic                   buf_nonempty_c;
    logic                   starve_c;
    logic                   head_kill_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   stall_c;

    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]        rf_wdata_q, rf_wdata_d;

    // Request qualification and buffer status.
    assign pipe_req_c     = wb_regwrite && (wb_rd != REG_ADDR_W'(0));
    assign pipe_data_c    = wb_memtoreg ? wb_readdata : wb_alu_result;
    assign buf_nonempty_c = (count != CNT_W'(0));
    assign starve_c       = buf_nonempty_c && (wait_cnt_q == WAIT_W'(MAX_WAIT));
    assign md_ready       = (count < CNT_W'(FIFO_DEPTH));
    assign push_c         = md_valid && md_ready && (md_rd != REG_ADDR_W'(0));

`ifdef WB_WAW_KILL_EN
    logic pipe_grant_c;
    assign head_kill_c  = buf_nonempty_c && head.kill;
    // A killed head never wins over the pipeline, so a starve cycle with a killed head grants the pipeline.
    assign pipe_grant_c = pipe_req_c && !(starve_c && !head_kill_c);
`else
    assign head_kill_c  = 1'b0;
`endif

    // Incoming muldiv result as a buffer entry.
    always_comb begin
        push_entry      = '0;
        push_entry.rd   = md_rd;
        push_entry.data = XLEN_DEFAULT'(md_data);
    end

    // Per-cycle grant: starving live head, then pipeline, then any buffered head.
    always_comb begin
        pop_c      = 1'b0;
        stall_c    = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (starve_c && !head_kill_c) begin
            pop_c      = 1'b1;
            stall_c    = pipe_req_c;
            rf_we_d    = 1'b1;
            rf_waddr_d = head.rd;
            rf_wdata_d = XLEN'(head.data);
        end else if (pipe_req_c) begin
            pop_c      = starve_c;
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd;
            rf_wdata_d = pipe_data_c;
        end else if (buf_nonempty_c) begin
            pop_c = 1'b1;
            if (!head_kill_c) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = head.rd;
                rf_wdata_d = XLEN'(head.data);
            end
        end
    end

    // Head wait counter: saturating while the head is held, cleared on pop or empty.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!buf_nonempty_c || pop_c) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    wb_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_c),
        .entry_i   (push_entry),
        .pop_i     (pop_c),
`ifdef WB_WAW_KILL_EN
        .kill_en_i (pipe_grant_c),
        .kill_rd_i (wb_rd),
`endif
        .head_o    (head),
        .count_o   (count)
    );

    // Registered write port and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign pipe_stall = stall_c;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign buf_count  = count;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback (MEM/WB stage outputs) and results returning from the multi-cycle multiply/divide unit. The pipeline normally has priority; multiply/divide results wait in a 2-entry buffer. An anti-starvation counter stalls the pipeline for one cycle when a buffered result has waited too long. The block sits between the MEM/WB register, the muldiv unit and the register file, and drives a registered write port.

## Interface

Parameters:
- XLEN, 64, data width of register-file writes
- MAX_WAIT, 4, number of denied cycles a buffered muldiv result tolerates before the pipeline is stalled (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- wb_regwrite  in  1  MEM/WB Regwrite
- wb_memtoreg  in  1  MEM/WB Memtoreg; selects wb_readdata (1) or wb_alu_result (0)
- wb_rd  in  5  MEM/WB destination register
- wb_readdata  in  XLEN  MEM/WB load data
- wb_alu_result  in  XLEN  MEM/WB ALU result
- md_valid  in  1  muldiv result valid
- md_ready  out  1  arbiter can accept a muldiv result
- md_rd  in  5  muldiv destination register
- md_data  in  XLEN  muldiv result
- pipe_stall  out  1  pipeline must hold MEM/WB and everything upstream this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- buf_count  out  2  buffered muldiv entries (0..2)

## Operation

- Pipeline request: pipe_req = wb_regwrite && wb_rd != 0. Pipeline data = wb_memtoreg ? wb_readdata : wb_alu_result.
- md_ready = (buf_count < 2); no dependence on same-cycle pop. A transfer occurs when md_valid && md_ready. A transfer with md_rd == 0 is accepted and discarded (not buffered).
- Buffer is FIFO, 2 entries; entries are written in arrival order.
- Starvation counter wait_cnt (4 bits): increments, saturating at MAX_WAIT, in every cycle the buffer is non-empty and the head is not popped. Clears on every pop and whenever the buffer is empty.
- starve = (wait_cnt == MAX_WAIT) && buffer non-empty.
- Grant, per cycle, in priority order:
  - starve: pop head, write head; pipe_stall = pipe_req. The pipeline re-presents the same MEM/WB contents next cycle.
  - pipe_req: write pipeline result; pipe_stall = 0.
  - buffer non-empty: pop head, write head.
  - otherwise no write.
- pipe_stall is never asserted when pipe_req = 0.
- Simultaneous push and pop: both take effect; buf_count unchanged.

## Timing

- Grant decision is combinational in cycle N; rf_we/rf_waddr/rf_wdata reflect it from posedge at the end of N (1-cycle latency). rf_we is high for exactly one cycle per write.
- A muldiv result accepted in cycle N into an empty buffer with no pipe_req in N+1 is written to rf outputs at the end of N+1 (earliest is 2 cycles after acceptance).
- Worst case muldiv head wait: MAX_WAIT + 1 cycles from becoming head to its grant.
- Reset (async, any time): buffer empty, buf_count = 0, wait_cnt = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, pipe_stall = 0, md_ready = 1. An in-flight buffered result is lost.

## Configuration

- WB_WAW_KILL_EN defined: each buffer entry carries a kill bit. When the pipeline is granted with wb_rd equal to a buffered entry's rd, that entry's kill bit is set. A killed head is popped in any cycle the pipeline does not need the port (including starve cycles, which then do not stall), produces no write, and clears wait_cnt.
- WB_WAW_KILL_EN undefined: no kill bit; WAW ordering is the upstream scoreboard's responsibility. Every buffered entry is eventually written.

## Structure

- Package wb_pkg: XLEN default, REG_ADDR_W = 5, typedef wb_entry_t {rd, data, kill (under WB_WAW_KILL_EN)}.
- Sub-module wb_fifo2: 2-entry FIFO of wb_entry_t with push/pop/count and, under WB_WAW_KILL_EN, a match-and-kill input (rd, enable).

## Test plan

- Pipeline only: wb_regwrite=1, wb_rd=5, wb_memtoreg=1, wb_readdata=0xAA -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA. With wb_rd=0 -> rf_we=0.
- Muldiv idle port: md_valid with md_rd=7, data=0x1234, no pipe_req -> rf write of reg 7 = 0x1234 two cycles after acceptance; buf_count 1 then 0.
- Backpressure: hold pipe_req high and push 3 muldiv results -> md_ready=0 after second accept, buf_count=2, third result held by producer.
- Starvation, MAX_WAIT=4: continuous pipe_req with one buffered entry -> pipe_stall=1 in exactly the 5th cycle after buffering, muldiv result written, pipeline result written next cycle unchanged.
- Reset mid-operation: assert reset with buf_count=2 and rf_we=1 -> all outputs at reset values immediately (async), md_ready=1, no writes after release.
- With WB_WAW_KILL_EN: buffer rd=9, then pipeline writes rd=9 -> buffered entry popped with no rf write; without the macro it is written later.
